// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Purpose:
//   This is the program-counter and next-address stage that sits directly in
//   front of the word-addressed instruction memory. It holds the PC and drives
//   it out as the memory address every cycle. It picks the next PC from four
//   sources: sequential, branch, jump and jump-register. It also supports
//   stall, detects a self-loop jump as HALT, keeps a saturating count of
//   retired fetches, and passes the fetched word downstream with a valid flag.
//
// Optional feature (macro FETCH_MISALIGN_TRAP_EN):
//   Defined   : reg_target is used unmasked. An advance that would load a
//               misaligned PC enters FAULT instead. FAULT raises fault, drops
//               instr_valid and freezes the unit until reset.
//   Undefined : reg_target[1:0] is forced to 2'b00. There is no FAULT state,
//               and fault is tied to 0.
//
// Ports:
//   clk           rising-edge clock
//   reset_n       asynchronous active-low reset
//   stall         hold PC and counter this cycle
//   branch_taken  take PC-relative branch (imm_ext words past pc+4)
//   imm_ext       sign-extended branch offset, in words
//   jump          take absolute jump to {pc_plus4[31:28], jump_index, 2'b00}
//   jump_index    jump word index
//   jump_reg      take register jump
//   reg_target    register jump target, byte address
//   instr_in      instruction memory read data
//   pc            current PC, which is also the instruction memory address
//   pc_plus4      pc + 4 (combinational, wraps modulo 2^32)
//   instr         instr_in passed through
//   instr_valid   fetched word is live this cycle
//   halted        unit is in HALT
//   fetch_count   PC advances since reset (saturating)
//   fault         misaligned target trapped (0 without the feature)
//   state         FSM state for observation: 0 RUN, 1 HALT, 2 FAULT
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          COUNT_W  = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [31:0]        imm_ext,
  input  logic               jump,
  input  logic [25:0]        jump_index,
  input  logic               jump_reg,
  input  logic [31:0]        reg_target,
  input  logic [31:0]        instr_in,
  output logic [31:0]        pc,
  output logic [31:0]        pc_plus4,
  output logic [31:0]        instr,
  output logic               instr_valid,
  output logic               halted,
  output logic [COUNT_W-1:0] fetch_count,
  output logic               fault,
  output logic [1:0]         state
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_HALT  = 2'd1;
`ifdef FETCH_MISALIGN_TRAP_EN
  localparam logic [1:0] ST_FAULT = 2'd2;
`endif

  localparam logic [COUNT_W-1:0] CNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

  logic [31:0]        pc_q;
  logic [COUNT_W-1:0] cnt_q;
  logic [1:0]         state_q;

  logic [31:0]        branch_tgt;
  logic [31:0]        jump_tgt;
  logic [31:0]        reg_tgt;
  logic [31:0]        next_pc;
  logic               advance;
  logic               halt_hit;
  logic [COUNT_W-1:0] cnt_inc;

  assign pc_plus4   = pc_q + 32'd4;
  // imm_ext is in words. Its top two bits fall off the shift, matching
  // modulo-2^32 arithmetic.
  assign branch_tgt = pc_plus4 + {imm_ext[29:0], 2'b00};
  assign jump_tgt   = {pc_plus4[31:28], jump_index, 2'b00};

`ifdef FETCH_MISALIGN_TRAP_EN
  assign reg_tgt = reg_target;
`else
  assign reg_tgt = {reg_target[31:2], 2'b00};
`endif

  // Bits that do not affect the result in every build. They are gathered here
  // so it is obvious they are ignored on purpose.
  logic [3:0] unused_bits;
  assign unused_bits = {imm_ext[31:30], reg_target[1:0]};

  always_comb begin
    next_pc = pc_plus4;
    if (jump_reg)          next_pc = reg_tgt;
    else if (jump)         next_pc = jump_tgt;
    else if (branch_taken) next_pc = branch_tgt;
  end

  assign advance  = (state_q == ST_RUN) && !stall;
  // A jump back onto itself is the end-of-program idiom. A register jump has
  // priority over jump, so a register jump can never be treated as a halt.
  assign halt_hit = jump && !jump_reg && (jump_tgt == pc_q);
  assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + CNT_ONE;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
      state_q <= ST_RUN;
    end else if (advance) begin
`ifdef FETCH_MISALIGN_TRAP_EN
      // The trap takes the place of the advance: the PC and the counter
      // both keep their current values.
      if (next_pc[1:0] != 2'b00) begin
        state_q <= ST_FAULT;
      end else
`endif
      begin
        pc_q  <= next_pc;
        cnt_q <= cnt_inc;
        if (halt_hit) state_q <= ST_HALT;
      end
    end
  end

  // instr_valid is a plain qualifier with no handshake. Downstream must
  // consume instr in any cycle where instr_valid is 1; there is no ready
  // signal, and stall is the only form of backpressure.
  assign pc          = pc_q;
  assign fetch_count = cnt_q;
  assign instr       = instr_in;
  assign instr_valid = advance;
  assign halted      = (state_q == ST_HALT);
  assign state       = state_q;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign fault       = (state_q == ST_FAULT);
`else
  assign fault       = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        stall = 1'b0, branch_taken = 1'b0, jump = 1'b0, jump_reg = 1'b0;
  logic [31:0] imm_ext = '0, reg_target = '0, instr_in = '0;
  logic [25:0] jump_index = '0;

  logic [31:0] pc, pc_plus4, instr;
  logic        instr_valid, halted, fault;
  logic [15:0] fetch_count;
  logic [1:0]  state;

  logic [31:0] s_pc, s_pc_plus4, s_instr;
  logic        s_instr_valid, s_halted, s_fault;
  logic [3:0]  s_fetch_count;
  logic [1:0]  s_state;

  fetch_unit dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .branch_taken(branch_taken),
    .imm_ext(imm_ext), .jump(jump), .jump_index(jump_index), .jump_reg(jump_reg),
    .reg_target(reg_target), .instr_in(instr_in), .pc(pc), .pc_plus4(pc_plus4),
    .instr(instr), .instr_valid(instr_valid), .halted(halted),
    .fetch_count(fetch_count), .fault(fault), .state(state)
  );

  // Narrow-counter instance used to check saturation.
  fetch_unit #(.COUNT_W(4)) dut_sat (
    .clk(clk), .reset_n(reset_n), .stall(stall), .branch_taken(branch_taken),
    .imm_ext(imm_ext), .jump(jump), .jump_index(jump_index), .jump_reg(jump_reg),
    .reg_target(reg_target), .instr_in(instr_in), .pc(s_pc), .pc_plus4(s_pc_plus4),
    .instr(s_instr), .instr_valid(s_instr_valid), .halted(s_halted),
    .fetch_count(s_fetch_count), .fault(s_fault), .state(s_state)
  );

  // ---------------------------------------------------------------- reference model
  logic [31:0] m_pc;
  int          m_cnt, m_cnt4;
  bit          m_halt, m_fault;
  int          vectors = 0, miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_cnt = 0; m_cnt4 = 0; m_halt = 0; m_fault = 0;
  endtask

  task automatic model_edge();
    logic [31:0] p4, jt, rt, tgt;
    if (m_halt || m_fault || stall) return;
    p4 = m_pc + 32'd4;
    jt = {p4[31:28], jump_index, 2'b00};
`ifdef FETCH_MISALIGN_TRAP_EN
    rt = reg_target;
`else
    rt = reg_target & 32'hFFFF_FFFC;
`endif
    if (jump_reg)          tgt = rt;
    else if (jump)         tgt = jt;
    else if (branch_taken) tgt = p4 + imm_ext * 32'd4;
    else                   tgt = p4;
    if (tgt[1:0] != 2'b00) begin
      m_fault = 1;
      return;
    end
    if (jump && !jump_reg && jt == m_pc) m_halt = 1;
    else m_pc = tgt;
    if (m_cnt < 65535) m_cnt++;
    if (m_cnt4 < 15) m_cnt4++;
  endtask

  task automatic check_regs(input string tag);
    chk({tag, ".pc"}, pc, m_pc);
    chk({tag, ".count"}, {16'h0, fetch_count}, m_cnt);
    chk({tag, ".count4"}, {28'h0, s_fetch_count}, m_cnt4);
    chk({tag, ".halted"}, {31'h0, halted}, {31'h0, m_halt});
    chk({tag, ".fault"}, {31'h0, fault}, {31'h0, m_fault});
  endtask

  // ---------------------------------------------------------------- driver tasks
  task automatic set_in(input bit s, input bit br, input logic [31:0] imm, input bit j,
                        input logic [25:0] ji, input bit jr, input logic [31:0] rt);
    stall = s; branch_taken = br; imm_ext = imm; jump = j; jump_index = ji;
    jump_reg = jr; reg_target = rt; instr_in = $urandom;
  endtask

  // Called at a negedge with the inputs already applied.
  task automatic step(input string tag);
    #1;
    chk({tag, ".valid"}, {31'h0, instr_valid}, {31'h0, (!m_halt && !m_fault && !stall)});
    chk({tag, ".pc4"}, pc_plus4, m_pc + 32'd4);
    chk({tag, ".instr"}, instr, instr_in);
    @(posedge clk);
    model_edge();
    #1;
    check_regs(tag);
    @(negedge clk);
  endtask

  // Reset is asserted between edges; its effect must be visible at once.
  task automatic do_reset(input string tag);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    model_reset();
    check_regs(tag);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    model_reset();
    #12;
    check_regs("por");
    @(negedge clk);
    reset_n = 1'b1;

    // Sequential fetch.
    set_in(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step("seq");
    chk("seq_pc_abs", pc, 32'h10);
    chk("seq_cnt_abs", {16'h0, fetch_count}, 32'd4);

    // Branches: jump to 0x18, then forward and backward offsets.
    set_in(0, 0, 0, 1, 26'h6, 0, 0);          step("j18");
    set_in(0, 1, 32'h0000_000A, 0, 0, 0, 0);  step("bfwd");
    chk("bfwd_abs", pc, 32'h44);
    set_in(0, 1, 32'hFFFF_FFFE, 0, 0, 0, 0);  step("bback");
    chk("bback_abs", pc, 32'h40);

    // Priority: jump beats branch. Then stall.
    set_in(0, 0, 0, 1, 26'h4, 0, 0);          step("j10");
    set_in(0, 1, 32'h0000_0100, 1, 26'h11, 0, 0); step("prio");
    chk("prio_abs", pc, 32'h44);
    for (int i = 0; i < 3; i++) begin
      set_in(1, 1, 32'h5, 1, 26'h3, i[0], 32'h80);
      step("stall");
    end
    chk("stall_abs", pc, 32'h44);

    // Register jump beats jump; wrap of pc_plus4 to zero.
    set_in(0, 1, 32'h1, 1, 26'h2, 1, 32'hFFFF_FFFC); step("jr_wrap");
    set_in(0, 0, 0, 0, 0, 0, 0);              step("wrap");
    chk("wrap_abs", pc, 32'h0);

    // Halt on self-loop, frozen afterwards, then asynchronous reset.
    set_in(0, 0, 0, 1, 26'h0F, 0, 0);         step("j3c");
    set_in(0, 0, 0, 1, 26'h0F, 0, 0);         step("halt");
    chk("halt_abs", {31'h0, halted}, 32'h1);
    chk("halt_pc_abs", pc, 32'h3C);
    for (int i = 0; i < 3; i++) begin
      set_in(0, 1, 32'h3, 0, 0, 0, 0);
      step("frozen");
    end
    do_reset("rst_halt");
    chk("rst_halt_abs", pc, 32'h0);

    // Register jump with low bits set.
    set_in(0, 0, 0, 0, 0, 1, 32'h0000_0052);  step("jr52");
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("jr52_fault_abs", {31'h0, fault}, 32'h1);
    chk("jr52_pc_abs", pc, 32'h0);
    set_in(0, 0, 0, 0, 0, 0, 0);              step("faulted");
`else
    chk("jr52_abs", pc, 32'h50);
`endif
    do_reset("rst_jr");

    // Saturation of the narrow counter.
    set_in(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) step("sat");
    chk("sat_abs", {28'h0, s_fetch_count}, 32'hF);

    // Reset while stalled.
    set_in(1, 0, 0, 0, 0, 0, 0);
    step("pre_rst_stall");
    do_reset("rst_stall");

    // Randomized phase.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] imm;
      imm = $urandom_range(0, 63) - 32'd32;
      set_in($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, imm,
             $urandom_range(0, 7) == 0, $urandom_range(0, 63), $urandom_range(0, 9) == 0,
             $urandom);
      step("rand");
      if (m_halt || m_fault) do_reset("rand_rst");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
